// File: rtl/seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_ctrl_if
// Groups the button-pulse inputs and the sequencing outputs of seq_ctrl.
//   master : button side / sequence generator side (drives BTN_*, reads outputs)
//   slave  : the controller itself (reads BTN_*, drives outputs)
// Signals:
//   BTN_START/STOP/STEP/MODE : one-cycle pulses from the button filters
//   FLTR_CE                  : debounce CE tick back to the button filters
//   SEQ_CE / SEQ_RST         : advance / restart pulses to the sequence generator
//   ADDR, SPEED              : current element index and speed level
//   RUN, PAUSED              : state flags
// ----------------------------------------------------------------------------
interface seq_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  BTN_START;
  logic                  BTN_STOP;
  logic                  BTN_STEP;
  logic                  BTN_MODE;
  logic                  FLTR_CE;
  logic                  SEQ_CE;
  logic                  SEQ_RST;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [1:0]            SPEED;
  logic                  RUN;
  logic                  PAUSED;

  modport master (
    output BTN_START, BTN_STOP, BTN_STEP, BTN_MODE,
    input  FLTR_CE, SEQ_CE, SEQ_RST, ADDR, SPEED, RUN, PAUSED
  );

  modport slave (
    input  BTN_START, BTN_STOP, BTN_STEP, BTN_MODE,
    output FLTR_CE, SEQ_CE, SEQ_RST, ADDR, SPEED, RUN, PAUSED
  );
endinterface

// File: rtl/seq_ctrl.sv
// ----------------------------------------------------------------------------
// seq_ctrl
// Run/pause/idle sequencing controller for the sequence generator. Consumes
// the debounced button pulses, produces step/restart pulses and the element
// address, and generates the shared FLTR_CE tick for the button filters.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : seq_ctrl_if.slave (button pulses in, sequencing outputs out)
// Parameters:
//   CE_DIV     : FLTR_CE period in CLK cycles (>=1)
//   RATE_BASE  : step period at speed 0 in CLK cycles (>=1)
//   SEQ_LEN    : sequence length, 2..2**ADDR_WIDTH
//   ADDR_WIDTH : width of ADDR
// Build option:
//   SEQ_CTRL_ONESHOT_EN : when defined, playback in RUN stops (returns to
//   IDLE with a SEQ_RST pulse) instead of wrapping ADDR back to 0.
// ----------------------------------------------------------------------------
module seq_ctrl #(
  parameter int CE_DIV     = 1024,
  parameter int RATE_BASE  = 16,
  parameter int SEQ_LEN    = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  seq_ctrl_if.slave  bus
);

  localparam int CE_W  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  // Holds RATE_BASE*8-1, the longest period minus one (speed 3).
  localparam int CNT_W = $clog2(RATE_BASE * 8);

`ifdef SEQ_CTRL_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t                state_reg;
  logic [CE_W-1:0]       ce_cnt_reg;
  logic [CE_W-1:0]       ce_cnt_next;
  logic [CNT_W-1:0]      rate_cnt_reg;
  logic [CNT_W-1:0]      period_m1;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [1:0]            speed_reg;
  logic                  fltr_ce_reg;
  logic                  seq_ce_reg;
  logic                  seq_rst_reg;
  logic                  run_reg;
  logic                  paused_reg;
  logic                  rate_term;
  logic                  addr_last;

  always_comb begin
    ce_cnt_next = (ce_cnt_reg == CE_W'(CE_DIV - 1)) ? '0 : ce_cnt_reg + 1'b1;
    // Truncation is harmless: the full period never exceeds 2**CNT_W.
    period_m1   = CNT_W'((RATE_BASE << speed_reg) - 1);
    rate_term   = (state_reg == S_RUN) && (rate_cnt_reg == period_m1);
    addr_last   = (addr_reg == ADDR_WIDTH'(SEQ_LEN - 1));
    addr_next   = addr_last ? '0 : addr_reg + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      ce_cnt_reg   <= '0;
      rate_cnt_reg <= '0;
      addr_reg     <= '0;
      speed_reg    <= '0;
      fltr_ce_reg  <= 1'b0;
      seq_ce_reg   <= 1'b0;
      seq_rst_reg  <= 1'b0;
      run_reg      <= 1'b0;
      paused_reg   <= 1'b0;
    end else begin
      // FLTR_CE is registered, so it is asserted for the cycle in which the
      // divider holds its terminal value.
      ce_cnt_reg  <= ce_cnt_next;
      fltr_ce_reg <= (ce_cnt_next == CE_W'(CE_DIV - 1));

      seq_ce_reg  <= 1'b0;
      seq_rst_reg <= 1'b0;

      // STOP > START > STEP
      case (state_reg)
        S_IDLE: begin
          if (bus.BTN_STOP) begin
            state_reg <= S_IDLE;
          end else if (bus.BTN_START) begin
            state_reg <= S_RUN;
            run_reg   <= 1'b1;
          end else if (bus.BTN_STEP) begin
            seq_ce_reg <= 1'b1;
            addr_reg   <= addr_next;
            state_reg  <= S_PAUSE;
            paused_reg <= 1'b1;
          end
        end
        S_RUN: begin
          // STOP suppresses a coincident terminal-count step.
          if (bus.BTN_STOP) begin
            state_reg  <= S_PAUSE;
            run_reg    <= 1'b0;
            paused_reg <= 1'b1;
          end else if (rate_term) begin
            if (ONESHOT && addr_last) begin
              state_reg   <= S_IDLE;
              run_reg     <= 1'b0;
              addr_reg    <= '0;
              seq_rst_reg <= 1'b1;
            end else begin
              seq_ce_reg <= 1'b1;
              addr_reg   <= addr_next;
            end
          end
        end
        S_PAUSE: begin
          if (bus.BTN_STOP) begin
            state_reg   <= S_IDLE;
            paused_reg  <= 1'b0;
            addr_reg    <= '0;
            seq_rst_reg <= 1'b1;
          end else if (bus.BTN_START) begin
            state_reg  <= S_RUN;
            run_reg    <= 1'b1;
            paused_reg <= 1'b0;
          end else if (bus.BTN_STEP) begin
            seq_ce_reg <= 1'b1;
            addr_reg   <= addr_next;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          run_reg    <= 1'b0;
          paused_reg <= 1'b0;
        end
      endcase

      // MODE acts regardless of state and restarts the step period. The rate
      // counter only advances while staying in RUN, so every entry into RUN
      // finds it at zero.
      if (bus.BTN_MODE) begin
        speed_reg    <= speed_reg + 2'd1;
        rate_cnt_reg <= '0;
      end else if ((state_reg == S_RUN) && !bus.BTN_STOP && !rate_term) begin
        rate_cnt_reg <= rate_cnt_reg + 1'b1;
      end else begin
        rate_cnt_reg <= '0;
      end
    end
  end

  assign bus.FLTR_CE = fltr_ce_reg;
  assign bus.SEQ_CE  = seq_ce_reg;
  assign bus.SEQ_RST = seq_rst_reg;
  assign bus.ADDR    = addr_reg;
  assign bus.SPEED   = speed_reg;
  assign bus.RUN     = run_reg;
  assign bus.PAUSED  = paused_reg;

endmodule

// File: tb/tb_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_ctrl
// Self-checking bench for seq_ctrl (CE_DIV=3, RATE_BASE=4, SEQ_LEN=5,
// ADDR_WIDTH=3). A schedule-based reference model predicts every output each
// cycle: it tracks the absolute cycle of the next automatic step instead of a
// counter, and derives FLTR_CE from the cycle number since reset release.
// ----------------------------------------------------------------------------
module tb_seq_ctrl;

  localparam int CE_DIV     = 3;
  localparam int RATE_BASE  = 4;
  localparam int SEQ_LEN    = 5;
  localparam int ADDR_WIDTH = 3;

  logic clk;
  logic rst;

  seq_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  seq_ctrl #(
    .CE_DIV     (CE_DIV),
    .RATE_BASE  (RATE_BASE),
    .SEQ_LEN    (SEQ_LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0=IDLE 1=RUN 2=PAUSE; m_c is the index of the
  // cycle whose outputs are currently visible (0 = first cycle after reset).
  int m_state, m_addr, m_speed, m_next, m_c;
  bit m_ce, m_rst;

  function automatic int period(input int sp);
    return RATE_BASE * (1 << sp);
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [9:0] v;
    v = {(m_c % CE_DIV) == (CE_DIV - 1), m_ce, m_rst, 3'(m_addr), 2'(m_speed),
         m_state == 1, m_state == 2};
    return v;
  endfunction

  function automatic logic [9:0] got_vec();
    return {bus.FLTR_CE, bus.SEQ_CE, bus.SEQ_RST, bus.ADDR, bus.SPEED, bus.RUN, bus.PAUSED};
  endfunction

  task automatic model_edge(input bit s, input bit t, input bit p, input bit m);
    int nc;
    bit term;
    nc    = m_c + 1;
    m_ce  = 0;
    m_rst = 0;
    term  = (m_state == 1) && (m_next == nc);
    if (t) begin
      if (m_state == 1) m_state = 2;
      else if (m_state == 2) begin m_state = 0; m_addr = 0; m_rst = 1; end
    end else if (m_state == 1) begin
      if (term) begin
`ifdef SEQ_CTRL_ONESHOT_EN
        if (m_addr == SEQ_LEN - 1) begin m_state = 0; m_addr = 0; m_rst = 1; end else
`endif
        begin m_ce = 1; m_addr = (m_addr + 1) % SEQ_LEN; m_next = nc + period(m_speed); end
      end
    end else if (s) begin
      m_state = 1;
      m_next  = nc + period(m_speed);
    end else if (p) begin
      m_ce = 1; m_addr = (m_addr + 1) % SEQ_LEN; m_state = 2;
    end
    if (m) begin
      m_speed = (m_speed + 1) % 4;
      m_next  = nc + period(m_speed);
    end
    m_c = nc;
  endtask

  // One clock cycle with the given one-cycle pulses; returns at the negedge.
  task automatic tick(input bit s, input bit t, input bit p, input bit m);
    bus.BTN_START = s; bus.BTN_STOP = t; bus.BTN_STEP = p; bus.BTN_MODE = m;
    @(posedge clk);
    model_edge(s, t, p, m);
    @(negedge clk);
    bus.BTN_START = 0; bus.BTN_STOP = 0; bus.BTN_STEP = 0; bus.BTN_MODE = 0;
  endtask

  task automatic do_reset(input bit s, input bit t, input bit p, input bit m);
    rst = 1'b1;
    bus.BTN_START = s; bus.BTN_STOP = t; bus.BTN_STEP = p; bus.BTN_MODE = m;
    @(posedge clk);
    m_state = 0; m_addr = 0; m_speed = 0; m_next = 0; m_c = 0; m_ce = 0; m_rst = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.BTN_START = 0; bus.BTN_STOP = 0; bus.BTN_STEP = 0; bus.BTN_MODE = 0;
  endtask

  task automatic test_reset();
    do_reset(0, 0, 0, 0);
    checks++;
    if (got_vec() !== 10'b0) begin
      errors++; $display("FAIL reset_values got %b expected %b", got_vec(), 10'b0);
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle cycle %0d got %b expected %b", m_c, got_vec(), exp_vec());
      end
    end
    $display("test_reset done at cycle %0d", m_c);
  endtask

  task automatic test_run();
    int ce_q[$];
    int addr_q[$];
    int rst_cyc;
    int exp_ce[$];
    int exp_addr[$];
`ifdef SEQ_CTRL_ONESHOT_EN
    exp_ce = '{15, 19, 23, 27};
    exp_addr = '{1, 2, 3, 4};
`else
    exp_ce = '{15, 19, 23, 27, 31};
    exp_addr = '{1, 2, 3, 4, 0};
`endif
    rst_cyc = -1;
    do_reset(0, 0, 0, 0);
    while (m_c < 31) begin
      tick(m_c == 10, 0, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL run cycle %0d got %b expected %b", m_c, got_vec(), exp_vec());
      end
      if (bus.SEQ_CE) begin ce_q.push_back(m_c); addr_q.push_back(int'(bus.ADDR)); end
      if (bus.SEQ_RST) rst_cyc = m_c;
    end
    checks++;
    if (ce_q.size() != exp_ce.size()) begin
      errors++; $display("FAIL run_step_count got %0d expected %0d", ce_q.size(), exp_ce.size());
    end else begin
      for (int i = 0; i < exp_ce.size(); i++) begin
        checks++;
        if (ce_q[i] != exp_ce[i] || addr_q[i] != exp_addr[i]) begin
          errors++;
          $display("FAIL run_step%0d got cycle %0d addr %0d expected cycle %0d addr %0d",
                   i, ce_q[i], addr_q[i], exp_ce[i], exp_addr[i]);
        end
      end
    end
`ifdef SEQ_CTRL_ONESHOT_EN
    checks++;
    if (rst_cyc != 31 || bus.RUN !== 1'b0) begin
      errors++; $display("FAIL oneshot_end got rst cycle %0d run %b expected 31 0", rst_cyc, bus.RUN);
    end
`endif
    $display("test_run done, %0d steps", ce_q.size());
  endtask

  task automatic test_mode();
    int t0;
    int ce_q[$];
    do_reset(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    t0 = m_c;
    checks++;
    if (bus.SPEED !== 2'd3) begin
      errors++; $display("FAIL mode_speed got %0d expected 3", bus.SPEED);
    end
    for (int i = 0; i < 70; i++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL mode cycle %0d got %b expected %b", m_c, got_vec(), exp_vec());
      end
      if (bus.SEQ_CE) ce_q.push_back(m_c - t0);
    end
    checks++;
    if (ce_q.size() != 2 || ce_q[0] != 32 || ce_q[1] != 64) begin
      errors++;
      $display("FAIL mode_period got %0d steps first offset %0d expected 2 steps at 32 64",
               ce_q.size(), (ce_q.size() > 0) ? ce_q[0] : -1);
    end
    $display("test_mode done");
  endtask

  task automatic test_pause_step();
    int n_ce;
    n_ce = 0;
    do_reset(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (bus.PAUSED !== 1'b1 || bus.RUN !== 1'b0 || bus.ADDR !== 3'd1) begin
      errors++; $display("FAIL pause_entry got paused %b run %b addr %0d expected 1 0 1",
                         bus.PAUSED, bus.RUN, bus.ADDR);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, (i == 2) || (i == 5), 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL pause cycle %0d got %b expected %b", m_c, got_vec(), exp_vec());
      end
      if (bus.SEQ_CE) n_ce++;
    end
    checks++;
    if (n_ce != 2 || bus.ADDR !== 3'd3) begin
      errors++; $display("FAIL pause_steps got %0d steps addr %0d expected 2 steps addr 3", n_ce, bus.ADDR);
    end
    tick(0, 1, 0, 0);
    checks++;
    if (bus.SEQ_RST !== 1'b1 || bus.ADDR !== 3'd0 || bus.PAUSED !== 1'b0 || bus.RUN !== 1'b0) begin
      errors++; $display("FAIL pause_stop got rst %b addr %0d paused %b run %b expected 1 0 0 0",
                         bus.SEQ_RST, bus.ADDR, bus.PAUSED, bus.RUN);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (bus.SEQ_RST !== 1'b0) begin
      errors++; $display("FAIL pause_rst_width got %b expected 0", bus.SEQ_RST);
    end
    $display("test_pause_step done");
  endtask

  task automatic test_coincide();
    do_reset(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    checks++;
    if (bus.RUN !== 1'b0 || bus.SEQ_RST !== 1'b0 || bus.PAUSED !== 1'b0) begin
      errors++; $display("FAIL coincide_idle got run %b rst %b paused %b expected 0 0 0",
                         bus.RUN, bus.SEQ_RST, bus.PAUSED);
    end
    tick(0, 0, 1, 0);
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++; $display("FAIL coincide_step got %b expected %b", got_vec(), exp_vec());
    end
    tick(1, 1, 0, 1);
    checks++;
    if (bus.SEQ_RST !== 1'b1 || bus.PAUSED !== 1'b0 || bus.RUN !== 1'b0 || bus.SPEED !== 2'd1) begin
      errors++; $display("FAIL coincide_pause got rst %b paused %b run %b speed %0d expected 1 0 0 1",
                         bus.SEQ_RST, bus.PAUSED, bus.RUN, bus.SPEED);
    end
    $display("test_coincide done");
  endtask

  task automatic test_reset_midrun();
    do_reset(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 0);
    do_reset(0, 0, 1, 0);
    checks++;
    if (got_vec() !== 10'b0) begin
      errors++; $display("FAIL reset_midrun got %b expected %b", got_vec(), 10'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_phase cycle %0d got %b expected %b", m_c, got_vec(), exp_vec());
      end
    end
    $display("test_reset_midrun done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(0, 1) == 0, 1'b0, $urandom_range(0, 1) == 0, 1'b0);
      end else begin
        tick($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 29) == 0);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random iter %0d cycle %0d got %b expected %b", i, m_c, got_vec(), exp_vec());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    bus.BTN_START = 0; bus.BTN_STOP = 0; bus.BTN_STEP = 0; bus.BTN_MODE = 0;
    test_reset();
    test_run();
    test_mode();
    test_pause_step();
    test_coincide();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Sequencing controller for the sequence generator. It takes the one-cycle CEO pulses from the debounced-button filters and runs a run/pause/idle state machine. From that it produces the step-enable, address and restart signals for the sequence generator. It also generates the shared CE tick that clocks the button filters' debounce counters, so one block both configures the filters and consumes their outputs.

## Interface
- CE_DIV, 1024: FLTR_CE period in CLK cycles, ≥1.
- RATE_BASE, 16: step period at speed 0 in CLK cycles, ≥1.
- SEQ_LEN, 16: sequence length in elements, 2..2^ADDR_WIDTH.
- ADDR_WIDTH, 4: width of ADDR.
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- BTN_START  in  1  one-cycle pulse, START button filter CEO.
- BTN_STOP  in  1  one-cycle pulse, STOP button filter CEO.
- BTN_STEP  in  1  one-cycle pulse, STEP button filter CEO.
- BTN_MODE  in  1  one-cycle pulse, MODE button filter CEO.
- FLTR_CE  out  1  tick to all button filters' CE inputs.
- SEQ_CE  out  1  one-cycle advance pulse to the sequence generator.
- SEQ_RST  out  1  one-cycle restart pulse to the sequence generator.
- ADDR  out  ADDR_WIDTH  current element index.
- SPEED  out  2  current speed level.
- RUN  out  1  high in state RUN.
- PAUSED  out  1  high in state PAUSE.

## Operation
- The state machine has three states: IDLE (reset state), RUN and PAUSE.
- Transitions, in priority order when pulses coincide (STOP > START > STEP):
  - IDLE: START goes to RUN; STEP issues one step and goes to PAUSE.
  - RUN: STOP goes to PAUSE; START and STEP are ignored.
  - PAUSE: START goes to RUN; STEP issues one step and stays in PAUSE; STOP goes to IDLE, pulses SEQ_RST and sets ADDR=0.
- A step means: SEQ_CE=1 for one cycle, and ADDR takes its new value on the same edge.
- ADDR wraps from SEQ_LEN-1 to 0.
- BTN_MODE is handled independently of the state priority: SPEED = (SPEED+1) mod 4, and the rate counter clears.
- Rate counter: counts CLK cycles only while in RUN.
  - Period P = RATE_BASE << SPEED.
  - When the count reaches P-1: issue a step and clear the counter.
  - The counter is cleared on every entry to RUN; the first step comes P cycles after RUN rises.
  - Counter width is the bit count of RATE_BASE*8-1.
- FLTR_CE: free-running divider that ignores state.
  - It pulses for one cycle every CE_DIV cycles.
  - With CE_DIV=1 it is constantly high.
- Reset values of all outputs: FLTR_CE=0, SEQ_CE=0, SEQ_RST=0, ADDR=0, SPEED=0, RUN=0, PAUSED=0. The state is IDLE and both counters are 0.

## Timing
- All outputs are registered.
- A button pulse sampled at edge n produces its state, RUN/PAUSED, ADDR, SEQ_CE and SEQ_RST changes at edge n+1 (latency 1).
- SEQ_CE and SEQ_RST are never high for two consecutive cycles from a single event, and never high in the same cycle.
- In RUN, consecutive SEQ_CE pulses are exactly P cycles apart.
- A MODE pulse in RUN restarts the period: the next step comes P' cycles after the MODE edge, where P' uses the new SPEED.
- STOP in the same cycle as a rate-counter terminal count: no step, go to PAUSE, ADDR unchanged.
- MODE together with STOP or START: both take effect in that cycle.
- RST is sampled synchronously:
  - RST high at edge n forces all reset values at edge n, overriding any coincident button pulse.
  - RST overrides mid-run: no SEQ_CE or SEQ_RST is generated.
- First FLTR_CE after reset release: high during cycle CE_DIV-1, counting the first cycle with RST low as cycle 0.

## Configuration
- SEQ_CTRL_ONESHOT_EN
  - Defined: in RUN, the step that would wrap ADDR from SEQ_LEN-1 to 0 is replaced by a move to IDLE: ADDR=0, SEQ_RST=1 for one cycle, no SEQ_CE.
  - STEP-issued wraps in PAUSE still wrap normally.
  - Not defined: ADDR wraps continuously in RUN and playback never stops on its own.

## Test plan
Bench parameters: CE_DIV=3, RATE_BASE=4, SEQ_LEN=5, ADDR_WIDTH=3.
- Reset then idle 12 cycles -> FLTR_CE high on cycles 2, 5, 8, 11; all other outputs at reset values; no SEQ_CE.
- START pulse at cycle 10 -> RUN=1 at cycle 11; SEQ_CE on cycles 15, 19, 23, 27, 31; ADDR sequence 1, 2, 3, 4, 0.
  - With SEQ_CTRL_ONESHOT_EN: the cycle-31 event is SEQ_RST, and RUN=0 from cycle 31.
- Three MODE pulses in RUN -> SPEED=3 and the period becomes 32 cycles, measured from the last MODE.
- STOP in RUN -> PAUSED=1, ADDR held; STEP x2 -> two SEQ_CE pulses, ADDR+2; second STOP -> SEQ_RST=1, ADDR=0, state IDLE.
- START and STOP in the same cycle from IDLE -> STOP wins, state stays IDLE, no SEQ_RST.
  - Same coincidence in PAUSE -> IDLE with SEQ_RST.
- RST asserted mid-RUN together with a STEP pulse -> next cycle all outputs at reset values, no SEQ_CE, and FLTR_CE phase restarts.
